// File: rtl/univ_reg.sv
// univ_reg: WIDTH-bit multi-mode register / counter primitive.
//
// Modes (applied on a rising clk edge when en=1 and clr=0):
//   000 hold         001 load d
//   010 shift left   (ser_lsb enters bit 0)
//   011 shift right  (ser_msb enters bit WIDTH-1)
//   100 rotate left  101 rotate right
//   110 count up     111 count down   (both modulo 2^WIDTH)
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (q <= RST_VAL)
//   clr         synchronous clear to RST_VAL, overrides en
//   en          clock enable
//   mode[2:0]   operation select
//   d           parallel load data
//   ser_lsb     serial input for shift left
//   ser_msb     serial input for shift right
//   q, qn       registered value and its complement
//   tc          terminal count: the next enabled count edge wraps.
//               Feeding tc into the en of a second instance builds a
//               2*WIDTH counter with no glue logic.
module univ_reg #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_lsb,
  input  logic             ser_msb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_UP   = 3'b110,
    M_DN   = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_nxt;

  // Any value not matching a listed mode (e.g. X in simulation) falls to
  // the default and holds q.
  always_comb begin
    q_nxt = q;
    case (mode)
      M_HOLD: q_nxt = q;
      M_LOAD: q_nxt = d;
      M_SHL:  q_nxt = {q[WIDTH-2:0], ser_lsb};
      M_SHR:  q_nxt = {ser_msb, q[WIDTH-1:1]};
      M_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
      M_UP:   q_nxt = q + 1'b1;
      M_DN:   q_nxt = q - 1'b1;
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= RST_VAL;
    else if (clr) q <= RST_VAL;
    else if (en)  q <= q_nxt;
  end

  assign qn = ~q;

  // Qualified with en and ~clr so a cascaded stage only advances on the
  // exact edge where this stage really wraps.
  assign tc = en & ~clr &
              (((mode == M_UP) & (q == {WIDTH{1'b1}})) |
               ((mode == M_DN) & (q == {WIDTH{1'b0}})));

endmodule

// File: tb/tb_univ_reg.sv
module tb_univ_reg;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic       clr, en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       ser_lsb, ser_msb;
  logic [7:0] q, qn, q2, qn2;
  logic       tc, tc2;

  logic       en_c;
  logic [7:0] q_lo, qn_lo, q_hi, qn_hi;
  logic       tc_lo, tc_hi;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  univ_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .d(d),
    .ser_lsb(ser_lsb), .ser_msb(ser_msb), .q(q), .qn(qn), .tc(tc)
  );

  univ_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut2 (
    .clk(clk), .rst_n(rst2_n), .clr(clr), .en(en), .mode(mode), .d(d),
    .ser_lsb(ser_lsb), .ser_msb(ser_msb), .q(q2), .qn(qn2), .tc(tc2)
  );

  univ_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_lo (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(en_c), .mode(3'b110),
    .d(8'h00), .ser_lsb(1'b0), .ser_msb(1'b0), .q(q_lo), .qn(qn_lo), .tc(tc_lo)
  );

  univ_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_hi (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(tc_lo), .mode(3'b110),
    .d(8'h00), .ser_lsb(1'b0), .ser_msb(1'b0), .q(q_hi), .qn(qn_hi), .tc(tc_hi)
  );

  // Reference next-state, written as plain arithmetic on integers.
  function automatic int ref_next(int cur, int md, int din, int sl, int sm);
    case (md)
      0: return cur;
      1: return din;
      2: return (cur * 2 + sl) % 256;
      3: return cur / 2 + sm * 128;
      4: return (cur * 2) % 256 + cur / 128;
      5: return cur / 2 + (cur % 2) * 128;
      6: return (cur + 1) % 256;
      default: return (cur + 255) % 256;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    clr = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00;
    ser_lsb = 1'b0; ser_msb = 1'b0; en_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (q !== 8'h00 || qn !== 8'hFF || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: q=%h qn=%h tc=%b want q=00 qn=ff tc=0", q, qn, tc);
    end
    rst_n = 1'b1; rst2_n = 1'b1;
    en = 1'b0; mode = 3'b001; d = 8'h5A;
    repeat (3) step();
    n_tests++;
    if (q !== 8'h00) begin
      n_fail++;
      $display("FAIL en_low_hold: q=%h want 00", q);
    end
  endtask

  task automatic test_load_shift();
    en = 1'b1; mode = 3'b001; d = 8'h81;
    step();
    n_tests++;
    if (q !== 8'h81) begin n_fail++; $display("FAIL load: q=%h want 81", q); end
    mode = 3'b010; ser_lsb = 1'b1;
    step();
    n_tests++;
    if (q !== 8'h03) begin n_fail++; $display("FAIL shl1: q=%h want 03", q); end
    step();
    n_tests++;
    if (q !== 8'h07) begin n_fail++; $display("FAIL shl2: q=%h want 07", q); end
    mode = 3'b011; ser_msb = 1'b0;
    step();
    n_tests++;
    if (q !== 8'h03) begin n_fail++; $display("FAIL shr: q=%h want 03", q); end
    ser_lsb = 1'b0;
  endtask

  task automatic test_rotate();
    mode = 3'b001; d = 8'h81;
    step();
    mode = 3'b100;
    step();
    n_tests++;
    if (q !== 8'h03 || qn !== 8'hFC) begin
      n_fail++; $display("FAIL rol: q=%h qn=%h want 03/fc", q, qn);
    end
    mode = 3'b101;
    step();
    n_tests++;
    if (q !== 8'h81 || qn !== 8'h7E) begin
      n_fail++; $display("FAIL ror1: q=%h qn=%h want 81/7e", q, qn);
    end
    step();
    n_tests++;
    if (q !== 8'hC0 || qn !== 8'h3F) begin
      n_fail++; $display("FAIL ror2: q=%h qn=%h want c0/3f", q, qn);
    end
  endtask

  task automatic test_count_wrap();
    mode = 3'b001; d = 8'hFE;
    step();
    mode = 3'b110;
    #1;
    n_tests++;
    if (tc !== 1'b0) begin n_fail++; $display("FAIL tc_at_fe: tc=%b want 0", tc); end
    step();
    n_tests++;
    if (q !== 8'hFF || tc !== 1'b1) begin
      n_fail++; $display("FAIL up_to_ff: q=%h tc=%b want ff/1", q, tc);
    end
    step();
    n_tests++;
    if (q !== 8'h00 || tc !== 1'b0) begin
      n_fail++; $display("FAIL up_wrap: q=%h tc=%b want 00/0", q, tc);
    end
    mode = 3'b111;
    #1;
    n_tests++;
    if (tc !== 1'b1) begin n_fail++; $display("FAIL dn_tc: tc=%b want 1", tc); end
    step();
    n_tests++;
    if (q !== 8'hFF) begin n_fail++; $display("FAIL dn_wrap: q=%h want ff", q); end
  endtask

  task automatic test_clr_collision();
    mode = 3'b001; d = 8'hFF;
    step();
    mode = 3'b110; clr = 1'b1; en = 1'b1;
    #1;
    n_tests++;
    if (tc !== 1'b0) begin n_fail++; $display("FAIL clr_tc: tc=%b want 0", tc); end
    step();
    n_tests++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL clr_wins: q=%h want 00", q); end
    clr = 1'b0; en = 1'b0;
    step();
    n_tests++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL en_low_after_clr: q=%h want 00", q); end
  endtask

  task automatic test_async_reset();
    en = 1'b1; mode = 3'b001; d = 8'h10;
    step();
    mode = 3'b110;
    step();
    step();
    n_tests++;
    if (q2 !== 8'h12) begin n_fail++; $display("FAIL pre_rst_count: q2=%h want 12", q2); end
    #2 rst2_n = 1'b0;
    #1;
    n_tests++;
    if (q2 !== 8'hA5 || qn2 !== 8'h5A) begin
      n_fail++; $display("FAIL async_rst: q2=%h qn2=%h want a5/5a", q2, qn2);
    end
    #2 rst2_n = 1'b1;
    #1;
    n_tests++;
    if (q2 !== 8'hA5) begin n_fail++; $display("FAIL rst_release_hold: q2=%h want a5", q2); end
    step();
    n_tests++;
    if (q2 !== 8'hA6) begin n_fail++; $display("FAIL post_rst_count: q2=%h want a6", q2); end
    en = 1'b0;
  endtask

  task automatic test_random();
    int m_q;
    int bad;
    bad = 0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    m_q = 0;
    for (int i = 0; i < 400; i++) begin
      int m_tc;
      mode    = 3'($urandom_range(0, 7));
      en      = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 15) == 0);
      d       = 8'($urandom);
      ser_lsb = 1'($urandom);
      ser_msb = 1'($urandom);
      // Occasionally steer q to a wrap boundary to exercise tc.
      if ($urandom_range(0, 9) == 0) begin
        mode = 3'b001; en = 1'b1; clr = 1'b0;
        d = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      end
      #1;
      m_tc = (en && !clr && ((mode == 3'b110 && m_q == 255) ||
                             (mode == 3'b111 && m_q == 0))) ? 1 : 0;
      n_tests++;
      if (tc !== 1'(m_tc)) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rand_tc[%0d]: tc=%b want %0d", i, tc, m_tc);
      end
      if (clr) m_q = 0;
      else if (en) m_q = ref_next(m_q, int'(mode), int'(d), int'(ser_lsb), int'(ser_msb));
      step();
      n_tests++;
      if (q !== 8'(m_q) || qn !== ~8'(m_q)) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rand_q[%0d]: q=%h qn=%h want %h", i, q, qn, 8'(m_q));
      end
    end
    clr = 1'b0; en = 1'b0;
  endtask

  task automatic test_cascade();
    n_tests++;
    if (q_lo !== 8'h00 || q_hi !== 8'h00) begin
      n_fail++; $display("FAIL cascade_start: lo=%h hi=%h want 00/00", q_lo, q_hi);
    end
    en_c = 1'b1;
    repeat (256) @(posedge clk);
    #1;
    n_tests++;
    if (q_hi !== 8'h01 || q_lo !== 8'h00 || tc_hi !== 1'b0) begin
      n_fail++;
      $display("FAIL cascade_256: hi=%h lo=%h tc_hi=%b want 01/00/0", q_hi, q_lo, tc_hi);
    end
    repeat (65536 - 256) @(posedge clk);
    #1;
    n_tests++;
    if (q_hi !== 8'h00 || q_lo !== 8'h00) begin
      n_fail++; $display("FAIL cascade_65536: hi=%h lo=%h want 00/00", q_hi, q_lo);
    end
    en_c = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_rotate();
    test_count_wrap();
    test_clr_collision();
    test_async_reset();
    test_random();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
